vga_ram_arb: RTL and testbench

//  Arbitrates one single-port synchronous sample RAM between the VGA display read path and the DDS waveform writer.

---
 rtl/vga_arb_pkg.sv | 33 +++
 rtl/vga_arb_starve_cnt.sv | 56 +++++
 rtl/vga_ram_arb.sv | 145 ++++++++++++++
 tb/tb_vga_ram_arb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_arb_pkg
// Description : Shared types for the VGA sample-RAM arbiter: FSM state
//               encodings (last RAM owner) and the per-cycle owner decision.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_arb_pkg;

  // Last owner of the RAM port; ST_IDLE when nothing was granted.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DISP = 2'd1,
    ST_WR   = 2'd2
  } state_e;

  // Owner selected by the arbiter in the current cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_WR   = 2'd2
  } owner_e;

  function automatic state_e owner_to_state(input owner_e own);
    case (own)
      OWN_DISP: return ST_DISP;
      OWN_WR:   return ST_WR;
      default:  return ST_IDLE;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_arb_starve_cnt.sv
`default_nettype none
// ============================================================================
// Module      : vga_arb_starve_cnt
// Description : Counts consecutive cycles the writer is requesting but denied,
//               saturating at LIM. When the count sits at LIM and the writer is
//               still requesting, o_force_wr demands a writer grant. A sticky
//               flag records every forced grant until cleared.
// Ports       : clk, rst_n        - clock, async active-low reset
//               i_wr_req/i_wr_gnt - writer request and grant this cycle
//               i_clr             - pulse, clears the sticky flag
//               o_force_wr        - force a writer grant this cycle
//               o_wr_starved      - sticky forced-grant flag
// Revision    : 1.0 - initial release
// ============================================================================
module vga_arb_starve_cnt #(
  parameter int LIM = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_wr_req,
  input  logic i_wr_gnt,
  input  logic i_clr,
  output logic o_force_wr,
  output logic o_wr_starved
);

  localparam int                 c_cnt_w = $clog2(LIM + 1);
  localparam logic [c_cnt_w-1:0] c_lim   = c_cnt_w'(LIM);

  logic [c_cnt_w-1:0] r_wait_cnt;
  logic               r_starved;

  assign o_force_wr   = i_wr_req && (r_wait_cnt == c_lim);
  assign o_wr_starved = r_starved;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_starved  <= 1'b0;
    end else begin
      if (!i_wr_req || i_wr_gnt) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != c_lim) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      // A set in the same cycle as a clear must not be lost.
      if (o_force_wr) begin
        r_starved <= 1'b1;
      end else if (i_clr) begin
        r_starved <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : vga_ram_arb
// Description : Arbitrates a single-port synchronous sample RAM between the
//               VGA display read path and the DDS waveform writer. Display
//               wins during active video, requesters alternate in blanking,
//               and a starvation guard forces a writer grant after STARVE_LIM
//               denied cycles. Grant -> RAM strobe (+1) -> read data (+2).
// Ports       : clk, rst_n                    - clock, async active-low reset
//               vid_active                    - inside visible window
//               disp_req/addr, disp_gnt       - display read request/grant
//               disp_rvalid, disp_rdata       - read return (latency 2)
//               wr_req/addr/data, wr_gnt      - writer request/grant
//               ram_re/we/addr/wdata, rdata   - RAM port
//               wr_starved, wr_starved_clr    - sticky starvation flag/clear
//               disp_stall_cnt                - denied display cycles
//                                               (only with VGA_RAM_ARB_STATS_EN)
// Config      : VGA_RAM_ARB_STATS_EN - adds the display stall counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_ram_arb
  import vga_arb_pkg::*;
#(
  parameter int AW         = 10,
  parameter int DW         = 10,
  parameter int STARVE_LIM = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vid_active,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_gnt,
  output logic          disp_rvalid,
  output logic [DW-1:0] disp_rdata,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  output logic          ram_re,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          wr_starved,
  input  logic          wr_starved_clr
`ifdef VGA_RAM_ARB_STATS_EN
  ,
  output logic [15:0]   disp_stall_cnt
`endif
);

  state_e        r_state;
  owner_e        w_owner;
  logic          w_force_wr;
  logic          r_ram_re;
  logic          r_ram_we;
  logic [AW-1:0] r_ram_addr;
  logic [DW-1:0] r_ram_wdata;
  logic          r_rvalid;

  vga_arb_starve_cnt #(
    .LIM (STARVE_LIM)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_wr_req     (wr_req),
    .i_wr_gnt     (wr_gnt),
    .i_clr        (wr_starved_clr),
    .o_force_wr   (w_force_wr),
    .o_wr_starved (wr_starved)
  );

  // Owner selection; first matching rule wins.
  always_comb begin
    w_owner = OWN_NONE;
    if (w_force_wr) begin
      w_owner = OWN_WR;
    end else if (vid_active) begin
      if (disp_req)    w_owner = OWN_DISP;
      else if (wr_req) w_owner = OWN_WR;
    end else if (disp_req && wr_req) begin
      // Alternate in blanking; an idle last owner counts as the writer.
      w_owner = (r_state == ST_DISP) ? OWN_WR : OWN_DISP;
    end else if (disp_req) begin
      w_owner = OWN_DISP;
    end else if (wr_req) begin
      w_owner = OWN_WR;
    end
  end

  assign disp_gnt = (w_owner == OWN_DISP);
  assign wr_gnt   = (w_owner == OWN_WR);

  // Last-owner FSM with the registered RAM port and read-valid pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_ram_re    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rvalid    <= 1'b0;
    end else begin
      r_state  <= owner_to_state(w_owner);
      r_ram_re <= disp_gnt;
      r_ram_we <= wr_gnt;
      if (disp_gnt) begin
        r_ram_addr <= disp_addr;
      end else if (wr_gnt) begin
        r_ram_addr <= wr_addr;
      end
      if (wr_gnt) begin
        r_ram_wdata <= wr_data;
      end
      r_rvalid <= r_ram_re;
    end
  end

  assign ram_re      = r_ram_re;
  assign ram_we      = r_ram_we;
  assign ram_addr    = r_ram_addr;
  assign ram_wdata   = r_ram_wdata;
  assign disp_rvalid = r_rvalid;
  // RAM data is valid the cycle after the strobe; pass it through only then.
  assign disp_rdata  = r_rvalid ? ram_rdata : '0;

`ifdef VGA_RAM_ARB_STATS_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (wr_starved_clr) begin
      r_stall_cnt <= '0;
    end else if (disp_req && !disp_gnt && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign disp_stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_ram_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_ram_arb
// Description : Self-checking bench for vga_ram_arb with a behavioural RAM,
//               a shadow memory and a read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_ram_arb;

  logic       clk;
  logic       rst_n;
  logic       vid_active;
  logic       disp_req;
  logic [9:0] disp_addr;
  logic       disp_gnt;
  logic       disp_rvalid;
  logic [9:0] disp_rdata;
  logic       wr_req;
  logic [9:0] wr_addr;
  logic [9:0] wr_data;
  logic       wr_gnt;
  logic       ram_re;
  logic       ram_we;
  logic [9:0] ram_addr;
  logic [9:0] ram_wdata;
  logic [9:0] ram_rdata;
  logic       wr_starved;
  logic       wr_starved_clr;
`ifdef VGA_RAM_ARB_STATS_EN
  logic [15:0] disp_stall_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  vga_ram_arb #(
    .AW         (10),
    .DW         (10),
    .STARVE_LIM (64)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .vid_active     (vid_active),
    .disp_req       (disp_req),
    .disp_addr      (disp_addr),
    .disp_gnt       (disp_gnt),
    .disp_rvalid    (disp_rvalid),
    .disp_rdata     (disp_rdata),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .ram_re         (ram_re),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .wr_starved     (wr_starved),
    .wr_starved_clr (wr_starved_clr)
`ifdef VGA_RAM_ARB_STATS_EN
    ,
    .disp_stall_cnt (disp_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Power-on RAM contents: (a*7+3) mod 1024.
  function automatic logic [9:0] init_val(input logic [9:0] a);
    return a * 10'd7 + 10'd3;
  endfunction

  // Behavioural synchronous single-port RAM.
  logic [9:0] mem_w [int];
  always @(posedge clk) begin
    if (ram_re) ram_rdata <= mem_w.exists(int'(ram_addr)) ? mem_w[int'(ram_addr)] : init_val(ram_addr);
    if (ram_we) mem_w[int'(ram_addr)] = ram_wdata;
  end

  // Scoreboard: expected read data pushed at grant, popped at disp_rvalid.
  typedef struct {
    logic [9:0] data;
    int         gcyc;
  } rd_t;
  rd_t        sb[$];
  logic [9:0] shadow [int];

  always @(negedge clk) begin : mon
    rd_t e;
    #2;
    if (rst_n) begin
      checks++;
      if (disp_gnt && wr_gnt) begin
        errors++;
        $display("FAIL one_grant: cyc=%0d disp_gnt=%b wr_gnt=%b, required at most one", cyc, disp_gnt, wr_gnt);
      end
      if (disp_rvalid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL rvalid_unexpected: cyc=%0d data=%h, no read outstanding", cyc, disp_rdata);
        end else begin
          e = sb.pop_front();
          if (disp_rdata !== e.data || cyc != e.gcyc + 2) begin
            errors++;
            $display("FAIL read_return: cyc=%0d data=%h, required cyc=%0d data=%h", cyc, disp_rdata, e.gcyc + 2, e.data);
          end
        end
      end
      if (wr_gnt) shadow[int'(wr_addr)] = wr_data;
      if (disp_gnt) begin
        e.data = shadow.exists(int'(disp_addr)) ? shadow[int'(disp_addr)] : init_val(disp_addr);
        e.gcyc = cyc;
        sb.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      disp_req       = 1'b0;
      wr_req         = 1'b0;
      wr_starved_clr = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vid_active = 1'b0; disp_req = 1'b0; disp_addr = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; wr_starved_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({disp_gnt, wr_gnt, disp_rvalid, ram_re, ram_we, wr_starved} !== 6'b0 ||
        disp_rdata !== 10'd0 || ram_addr !== 10'd0 || ram_wdata !== 10'd0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rv=%b re=%b we=%b st=%b addr=%h wd=%h rd=%h, required all 0",
               disp_gnt, wr_gnt, disp_rvalid, ram_re, ram_we, wr_starved, ram_addr, ram_wdata, disp_rdata);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); vid_active = 1'b1; disp_addr = 10'd7; disp_req = 1'b1;
    #1; checks++;
    if (disp_gnt !== 1'b1) begin
      errors++; $display("FAIL reset_pre_read_gnt: disp_gnt=%b, required 1", disp_gnt);
    end
    // Reset while the read is in flight.
    @(negedge clk); disp_req = 1'b0; rst_n = 1'b0;
    #1; checks++;
    if ({ram_re, ram_we, disp_rvalid, disp_gnt, wr_gnt} !== 5'b0 || ram_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_mid_read: re=%b we=%b rv=%b addr=%h, required 0", ram_re, ram_we, disp_rvalid, ram_addr);
    end
    sb.delete();
    @(negedge clk); rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk); #1; checks++;
      if (disp_rvalid !== 1'b0) begin
        errors++; $display("FAIL reset_no_rvalid: disp_rvalid=%b, required 0", disp_rvalid);
      end
    end
    vid_active = 1'b0;
  endtask

  task automatic test_writer_alone();
    @(negedge clk); vid_active = 1'b0; wr_req = 1'b1; wr_addr = 10'd3; wr_data = 10'h3FF;
    #1; checks++;
    if (wr_gnt !== 1'b1 || disp_gnt !== 1'b0) begin
      errors++; $display("FAIL wr_alone_gnt: wr_gnt=%b disp_gnt=%b, required 1/0", wr_gnt, disp_gnt);
    end
    @(negedge clk); wr_req = 1'b0;
    #1; checks++;
    if (ram_we !== 1'b1 || ram_re !== 1'b0 || ram_addr !== 10'd3 || ram_wdata !== 10'h3FF) begin
      errors++;
      $display("FAIL wr_alone_ram: we=%b re=%b addr=%h wd=%h, required 1/0/003/3ff", ram_we, ram_re, ram_addr, ram_wdata);
    end
    @(negedge clk); vid_active = 1'b1; wr_req = 1'b1; wr_addr = 10'd9; wr_data = 10'h155;
    #1; checks++;
    if (wr_gnt !== 1'b1) begin
      errors++; $display("FAIL wr_alone_active_gnt: wr_gnt=%b, required 1", wr_gnt);
    end
    // Read back the first write.
    @(negedge clk); wr_req = 1'b0; disp_req = 1'b1; disp_addr = 10'd3;
    @(negedge clk); disp_req = 1'b0;
    @(negedge clk); #1; checks++;
    if (disp_rvalid !== 1'b1 || disp_rdata !== 10'h3FF) begin
      errors++; $display("FAIL wr_readback: rv=%b data=%h, required 1/3ff", disp_rvalid, disp_rdata);
    end
    idle(3);
    vid_active = 1'b0;
  endtask

  task automatic test_blanking();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vid_active = 1'b0; disp_req = 1'b1; wr_req = 1'b1;
      disp_addr = (i == 0) ? 10'd5 : 10'(100 + i);
      wr_addr = 10'(200 + i); wr_data = 10'(i);
      #1; checks++;
      if (disp_gnt !== (i % 2 == 0) || wr_gnt !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL blank_alternate: i=%0d disp_gnt=%b wr_gnt=%b, required %b/%b", i, disp_gnt, wr_gnt, (i % 2 == 0), (i % 2 == 1));
      end
      if (i == 1) begin
        checks++;
        if (disp_rvalid !== 1'b0) begin
          errors++; $display("FAIL blank_latency_early: disp_rvalid=%b, required 0", disp_rvalid);
        end
      end
      if (i == 2) begin
        checks++;
        if (disp_rvalid !== 1'b1 || disp_rdata !== 10'd38) begin
          errors++; $display("FAIL blank_read_addr5: rv=%b data=%0d, required 1/38", disp_rvalid, disp_rdata);
        end
      end
    end
    idle(3);
  endtask

  task automatic test_starve();
    int first_wr = 0;
    int n_wr = 0;
    int n_disp = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      vid_active = 1'b1; disp_req = 1'b1; wr_req = 1'b1;
      disp_addr = 10'(i); wr_addr = 10'd20; wr_data = 10'h2AA;
      #1;
      if (wr_gnt) begin
        n_wr++;
        if (first_wr == 0) first_wr = i;
      end
      if (disp_gnt) n_disp++;
      if (i == 65) begin
        checks++;
        if (wr_gnt !== 1'b1 || disp_gnt !== 1'b0 || wr_starved !== 1'b0) begin
          errors++; $display("FAIL starve_force: wr_gnt=%b disp_gnt=%b st=%b, required 1/0/0", wr_gnt, disp_gnt, wr_starved);
        end
      end
      if (i == 66) begin
        checks++;
        if (wr_starved !== 1'b1 || disp_gnt !== 1'b1) begin
          errors++; $display("FAIL starve_flag: st=%b disp_gnt=%b, required 1/1", wr_starved, disp_gnt);
        end
      end
    end
    checks++;
    if (n_wr != 1 || first_wr != 65 || n_disp != 99) begin
      errors++; $display("FAIL starve_counts: wr=%0d first=%0d disp=%0d, required 1/65/99", n_wr, first_wr, n_disp);
    end
    idle(3);
  endtask

  task automatic test_starved_clr();
    @(negedge clk); wr_starved_clr = 1'b1;
    @(negedge clk); wr_starved_clr = 1'b0;
    #1; checks++;
    if (wr_starved !== 1'b0) begin
      errors++; $display("FAIL clr_plain: wr_starved=%b, required 0", wr_starved);
    end
    for (int i = 1; i <= 66; i++) begin
      @(negedge clk);
      vid_active = 1'b1; disp_req = 1'b1; wr_req = 1'b1;
      disp_addr = 10'(300 + i); wr_addr = 10'd21; wr_data = 10'h0F0;
      wr_starved_clr = (i == 65);
      #1;
      if (i == 65) begin
        checks++;
        if (wr_gnt !== 1'b1) begin
          errors++; $display("FAIL clr_force_gnt: wr_gnt=%b, required 1", wr_gnt);
        end
      end
      if (i == 66) begin
        checks++;
        if (wr_starved !== 1'b1) begin
          errors++; $display("FAIL clr_set_wins: wr_starved=%b, required 1", wr_starved);
        end
      end
    end
    idle(3);
  endtask

`ifdef VGA_RAM_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk); wr_starved_clr = 1'b1;
    @(negedge clk); wr_starved_clr = 1'b0;
    #1; checks++;
    if (disp_stall_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_clear0: cnt=%0d, required 0", disp_stall_cnt);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vid_active = 1'b0; disp_req = 1'b1; wr_req = 1'b1;
      disp_addr = 10'(400 + i); wr_addr = 10'(500 + i); wr_data = 10'(i);
    end
    @(negedge clk); disp_req = 1'b0; wr_req = 1'b0;
    #1; checks++;
    if (disp_stall_cnt !== 16'd10) begin
      errors++; $display("FAIL stats_count: cnt=%0d, required 10", disp_stall_cnt);
    end
    @(negedge clk); wr_starved_clr = 1'b1;
    @(negedge clk); wr_starved_clr = 1'b0;
    #1; checks++;
    if (disp_stall_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_clear: cnt=%0d, required 0", disp_stall_cnt);
    end
    idle(3);
  endtask
`endif

  initial begin
    test_reset();
    test_writer_alone();
    test_blanking();
    test_starve();
    test_starved_clr();
`ifdef VGA_RAM_ARB_STATS_EN
    test_stats();
`endif
    idle(4);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drained: outstanding=%0d, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
